// File: rtl/cwm_bank_mem_if.sv
// Read-burst / write bus for the banked weight memory.
// CWM_BCAST_WR_EN adds wr_bcast for all-bank writes.
interface cwm_bank_mem_if #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 4096,
    parameter int NUM_BANK   = 2
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int LW = AW + 1;

    logic                  rd_start;
    logic [BW-1:0]         rd_bank;
    logic [AW-1:0]         rd_base;
    logic [LW-1:0]         rd_len;
    logic                  rd_busy;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_vld;
    logic                  dout_last;
    logic                  rd_done;
    logic                  wr_en;
    logic [BW-1:0]         wr_bank;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] din;
`ifdef CWM_BCAST_WR_EN
    logic                  wr_bcast;
`endif

    modport slave (
`ifdef CWM_BCAST_WR_EN
        input  wr_bcast,
`endif
        input  rd_start, rd_bank, rd_base, rd_len, wr_en, wr_bank, wr_addr, din,
        output rd_busy, rd_err, dout, dout_vld, dout_last, rd_done
    );

    modport master (
`ifdef CWM_BCAST_WR_EN
        output wr_bcast,
`endif
        output rd_start, rd_bank, rd_base, rd_len, wr_en, wr_bank, wr_addr, din,
        input  rd_busy, rd_err, dout, dout_vld, dout_last, rd_done
    );
endinterface

// File: rtl/cwm_bank_mem.sv
// Banked weight memory with a burst read engine and pipelined read data.
// Optional CWM_BCAST_WR_EN: wr_bcast writes din to every bank at once.
module cwm_bank_mem #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 4096,
    parameter int NUM_BANK   = 2,
    parameter int NUM_PIPE   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    cwm_bank_mem_if.slave   bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int BW     = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int LW     = AW + 1;
    localparam int STAGES = NUM_PIPE + 1;
    localparam logic [BW:0] NB = (BW+1)'(NUM_BANK);

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q;
    logic [BW-1:0]   bank_q;
    logic [AW-1:0]   addr_q;
    logic [LW-1:0]   cnt_q;
    logic            busy_q;
    logic            err_q;
    logic            zdone_q;
    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] last_pipe;
    logic [STAGES:1][DATA_WIDTH-1:0] data_pipe;

    logic [DATA_WIDTH-1:0] mem [NUM_BANK][DEPTH];

    logic rd_bank_ok, accept, reject, done_w, wr_all;

    assign rd_bank_ok = {1'b0, bus.rd_bank} < NB;
    assign accept     = bus.rd_start && !busy_q && rd_bank_ok;
    assign reject     = bus.rd_start && (busy_q || !rd_bank_ok);
    // Zero-length bursts complete without ever touching the read pipe
    assign done_w     = (vld_pipe[STAGES] & last_pipe[STAGES]) | zdone_q;

`ifdef CWM_BCAST_WR_EN
    assign wr_all = bus.wr_bcast;
`else
    assign wr_all = 1'b0;
`endif

    // Out-of-range wr_bank matches no bank, so the write is dropped
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANK; b++) begin
            if (bus.wr_en && (wr_all || bus.wr_bank == BW'(b)))
                mem[b][bus.wr_addr] <= bus.din;
        end
    end

    // vld_pipe[0]/last_pipe[0] mark the issue cycle; stage STAGES drives dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bank_q    <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            zdone_q   <= 1'b0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            data_pipe <= '0;
        end else begin
            err_q   <= reject;
            zdone_q <= accept && (bus.rd_len == '0);
            if (accept)
                busy_q <= 1'b1;
            else if (done_w)
                busy_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept && bus.rd_len != '0) begin
                        state_q      <= RUN;
                        bank_q       <= bus.rd_bank;
                        addr_q       <= bus.rd_base;
                        cnt_q        <= bus.rd_len;
                        vld_pipe[0]  <= 1'b1;
                        last_pipe[0] <= (bus.rd_len == LW'(1));
                    end
                end
                RUN: begin
                    if (cnt_q == LW'(1)) begin
                        state_q      <= IDLE;
                        vld_pipe[0]  <= 1'b0;
                        last_pipe[0] <= 1'b0;
                    end else begin
                        cnt_q        <= cnt_q - LW'(1);
                        addr_q       <= addr_q + AW'(1);
                        last_pipe[0] <= (cnt_q == LW'(2));
                    end
                end
                default: state_q <= IDLE;
            endcase

            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1] & vld_pipe[k-1];
            end
            // Read-first: the array read sees the value before this edge's write
            if (vld_pipe[0])
                data_pipe[1] <= mem[bank_q][addr_q];
            for (int k = 2; k <= STAGES; k++) begin
                if (vld_pipe[k-1])
                    data_pipe[k] <= data_pipe[k-1];
            end
        end
    end

    assign bus.rd_busy   = busy_q;
    assign bus.rd_err    = err_q;
    assign bus.dout      = data_pipe[STAGES];
    assign bus.dout_vld  = vld_pipe[STAGES];
    assign bus.dout_last = last_pipe[STAGES];
    assign bus.rd_done   = done_w;
endmodule

// File: tb/tb_cwm_bank_mem.sv
// Directed bench for cwm_bank_mem: bursts, wrap, busy reject, read-first,
// zero length, bad bank, mid-burst reset and (with CWM_BCAST_WR_EN) broadcast.
module tb_cwm_bank_mem;
    localparam int DW = 32, DEPTH = 4096, NB = 3, NP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cwm_bank_mem_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANK(NB)) bus();

    cwm_bank_mem #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANK(NB), .NUM_PIPE(NP)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int bank, input int addr, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_bank = 2'(bank);
        bus.wr_addr = 12'(addr);
        bus.din     = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, bus.rd_busy, 1'b0);
        chk({tag, ".err"},  bus.rd_err, 1'b0);
        chk({tag, ".vld"},  bus.dout_vld, 1'b0);
        chk({tag, ".last"}, bus.dout_last, 1'b0);
        chk({tag, ".done"}, bus.rd_done, 1'b0);
        chk({tag, ".dout"}, bus.dout, '0);
    endtask

    // Cycle 0 holds rd_start; inj re-strikes rd_start while busy; wr_c writes
    // wdat to the burst's first address in that cycle.
    task automatic burst(input string tag, input int bank, input int base, input int len,
                         input int inj, input int wr_c, input logic [DW-1:0] wdat);
        int  dc;
        bit  ev;
        dc = (len == 0) ? 1 : len + NP + 1;
        bus.rd_start = 1'b1;
        bus.rd_bank  = 2'(bank);
        bus.rd_base  = 12'(base);
        bus.rd_len   = 13'(len);
        for (int c = 1; c <= len + NP + 4; c++) begin
            step();
            ev = (len > 0) && (c >= NP + 2) && (c < NP + 2 + len);
            chk($sformatf("%s.busy@%0d", tag, c), bus.rd_busy, (c <= dc));
            chk($sformatf("%s.err@%0d", tag, c),  bus.rd_err, (inj > 0 && c == inj + 1));
            chk($sformatf("%s.vld@%0d", tag, c),  bus.dout_vld, ev);
            chk($sformatf("%s.last@%0d", tag, c), bus.dout_last, (len > 0 && c == dc));
            chk($sformatf("%s.done@%0d", tag, c), bus.rd_done, (c == dc));
            if (ev)
                chk($sformatf("%s.dout@%0d", tag, c), bus.dout, exp_q[c-NP-2]);
            else if (len > 0 && c > dc)
                chk($sformatf("%s.hold@%0d", tag, c), bus.dout, exp_q[len-1]);
            bus.rd_start = (c == inj);
            if (c == inj) bus.rd_len = 13'd2;
            bus.wr_en = (c == wr_c);
            if (c == wr_c) begin
                bus.wr_bank = 2'(bank);
                bus.wr_addr = 12'(base);
                bus.din     = wdat;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_start = 1'b0; bus.rd_bank = '0; bus.rd_base = '0; bus.rd_len = '0;
        bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_addr = '0; bus.din = '0;
`ifdef CWM_BCAST_WR_EN
        bus.wr_bcast = 1'b0;
`endif
        repeat (3) step();
        chk_idle("rst");
        rst_n = 1'b1;
        step();

        // Bank 1 words 16..23, data out cycles 4..11
        for (int i = 0; i < 8; i++) wr(1, i, DW'(i + 16));
        exp_q = {};
        for (int i = 0; i < 8; i++) exp_q.push_back(DW'(i + 16));
        burst("b1", 1, 0, 8, -1, -1, '0);

        // Address wrap plus a rejected strike while busy
        wr(0, 4094, 32'hA0); wr(0, 4095, 32'hA1); wr(0, 0, 32'hA2); wr(0, 1, 32'hA3);
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        burst("wrap", 0, 4094, 4, 3, -1, '0);

        // Read-first collision, then re-read sees the new value
        wr(0, 100, 32'h55);
        exp_q = '{32'h55};
        burst("rf", 0, 100, 1, -1, 1, 32'hAA);
        exp_q = '{32'hAA};
        burst("rf2", 0, 100, 1, -1, -1, '0);

        exp_q = {};
        burst("zero", 2, 0, 0, -1, -1, '0);

        // Bank 3 is out of range: write dropped, no aliasing into other banks
        wr(2, 0, 32'h22);
        wr(3, 0, 32'hDEAD);
        exp_q = '{32'h22};
        burst("b2", 2, 0, 1, -1, -1, '0);
        exp_q = '{32'd16, 32'd17};
        burst("b1a", 1, 0, 2, -1, -1, '0);
        exp_q = '{32'hA2};
        burst("b0a", 0, 0, 1, -1, -1, '0);

        bus.rd_start = 1'b1; bus.rd_bank = 2'd3; bus.rd_base = '0; bus.rd_len = 13'd4;
        step();
        bus.rd_start = 1'b0;
        chk("badbank.err", bus.rd_err, 1'b1);
        chk("badbank.busy", bus.rd_busy, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("badbank.err@%0d", c), bus.rd_err, 1'b0);
            chk($sformatf("badbank.vld@%0d", c), bus.dout_vld, 1'b0);
            chk($sformatf("badbank.done@%0d", c), bus.rd_done, 1'b0);
        end

        // Reset on the third output word of an 8-word burst
        bus.rd_start = 1'b1; bus.rd_bank = 2'd1; bus.rd_base = '0; bus.rd_len = 13'd8;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) bus.rd_start = 1'b0;
        end
        chk("mid.vld", bus.dout_vld, 1'b1);
        chk("mid.dout", bus.dout, 32'd18);
        rst_n = 1'b0;
        #1;
        chk_idle("mid.rst");
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("mid.done@%0d", c), bus.rd_done, 1'b0);
            chk($sformatf("mid.vld@%0d", c), bus.dout_vld, 1'b0);
        end
        rst_n = 1'b1;
        step();
        exp_q = {};
        for (int i = 0; i < 8; i++) exp_q.push_back(DW'(i + 16));
        burst("post", 1, 0, 8, -1, -1, '0);

`ifdef CWM_BCAST_WR_EN
        bus.wr_bcast = 1'b1;
        wr(1, 5, 32'h77);
        bus.wr_bcast = 1'b0;
        exp_q = '{32'h77};
        for (int b = 0; b < NB; b++) burst($sformatf("bc%0d", b), b, 5, 1, -1, -1, '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
